// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RAM port arbiter.
//   ADDR_W_DEF / DEPTH_DEF : default word-address width and implemented depth
//   master_id_t            : identifies one of the two masters (0 = CPU, 1 = DMA)
//   RD_OOB_DATA            : read data returned for an out-of-range read
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned DEPTH_DEF  = 6000;

  typedef logic master_id_t;

  localparam logic [31:0] RD_OOB_DATA = 32'h0;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: bundles both Avalon-MM master ports and the RAM slave
// port of the arbiter.
//   m0_* / m1_*  : address, read, write, byteenable, writedata from the masters;
//                  waitrequest, readdata, readdatavalid back to the masters
//   ram_*        : address, byteenable, writedata, chipselect, write, clken to
//                  the RAM; readdata from the RAM
// Modports: slave (arbiter side), master (the agents driving the bus).
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_write;
  logic [3:0]        m0_byteenable;
  logic [31:0]       m0_writedata;
  logic              m0_waitrequest;
  logic [31:0]       m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [3:0]        m1_byteenable;
  logic [31:0]       m1_writedata;
  logic              m1_waitrequest;
  logic [31:0]       m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_writedata;
  logic              ram_chipselect;
  logic              ram_write;
  logic              ram_clken;
  logic [31:0]       ram_readdata;

  modport slave (
    input  m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_writedata, ram_chipselect,
    output ram_write, ram_clken,
    input  ram_readdata
  );

  modport master (
    output m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_writedata, ram_chipselect,
    input  ram_write, ram_clken,
    output ram_readdata
  );

endinterface

// File: rtl/rr_grant2.sv
// rr_grant2: combinational two-way weighted round-robin grant.
//   clk, reset  : clock, synchronous active-high reset
//   req_i[1:0]  : request per master
//   grant_o[1:0]: one-hot grant, same cycle as the request (none during reset)
//   grant_id_o  : index of the granted master (meaningful only when granted)
//
// register     | meaning
// last_grant_q | master that received the most recent grant
// burst_cnt_q  | consecutive grants to last_grant_q, saturating at MAX_BURST
//
// Reset leaves last_grant=1 with a full burst so m0 wins the first contention.
module rr_grant2
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o,
  output master_id_t grant_id_o
);

  localparam int unsigned    CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  master_id_t       last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  master_id_t       win;

  always_comb begin
    win     = last_grant_q;
    grant_o = 2'b00;
    if (!reset) begin
      case (req_i)
        2'b01: begin
          win     = 1'b0;
          grant_o = 2'b01;
        end
        2'b10: begin
          win     = 1'b1;
          grant_o = 2'b10;
        end
        2'b11: begin
          // The current holder keeps the port until its burst is used up.
          win     = (burst_cnt_q < CNT_MAX) ? last_grant_q : ~last_grant_q;
          grant_o = win ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign grant_id_o = win;

  always_comb begin
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    if (grant_o != 2'b00) begin
      last_grant_d = win;
      if (win != last_grant_q) begin
        burst_cnt_d = CNT_W'(1);
      end else if (burst_cnt_q < CNT_MAX) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      burst_cnt_q  <= CNT_MAX;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a single-port, 1-cycle-latency RAM between the CPU
// data master (m0) and the solver DMA (m1), one transfer per cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ram_port_arbiter_if.slave -- both master ports and RAM port
//   err_oob    : sticky out-of-range access flag
// Build option RAM_ARB_BOUNDS_CHECK_EN: accesses at or above DEPTH are
// accepted but kept off the RAM, reads return RD_OOB_DATA, err_oob latches.
// Without it no address check is made and err_oob is 0.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus,
  output logic                err_oob
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("ram_port_arbiter: MAX_BURST must be at least 1");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("ram_port_arbiter: DEPTH does not fit in ADDR_W");
  end

  logic [1:0]        req;
  logic [1:0]        grant;
  master_id_t        grant_id;
  logic              any_grant;
  logic              sel_write;
  logic              oob;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wd;

  logic              rd_pend_q, rd_pend_d;
  master_id_t        rd_owner_q, rd_owner_d;
  logic              rd_oob_q, rd_oob_d;
  logic              rd_live;
  logic [31:0]       rdata;

  // A write with read also high is a write.
  assign req[0] = bus.m0_read | bus.m0_write;
  assign req[1] = bus.m1_read | bus.m1_write;

  rr_grant2 #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_grant2 (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign any_grant = |grant;

  assign bus.m0_waitrequest = req[0] & ~grant[0];
  assign bus.m1_waitrequest = req[1] & ~grant[1];

  // m0 fields are presented whenever m1 does not own the port.
  always_comb begin
    sel_addr  = bus.m0_address;
    sel_be    = bus.m0_byteenable;
    sel_wd    = bus.m0_writedata;
    sel_write = grant[0] & bus.m0_write;
    if (grant[1]) begin
      sel_addr  = bus.m1_address;
      sel_be    = bus.m1_byteenable;
      sel_wd    = bus.m1_writedata;
      sel_write = bus.m1_write;
    end
  end

`ifdef RAM_ARB_BOUNDS_CHECK_EN
  assign oob = any_grant & (32'(sel_addr) >= DEPTH);
`else
  assign oob = 1'b0;
`endif

  assign bus.ram_address    = sel_addr;
  assign bus.ram_byteenable = sel_be;
  assign bus.ram_writedata  = sel_wd;
  assign bus.ram_chipselect = any_grant & ~oob;
  assign bus.ram_write      = sel_write & ~oob;
  assign bus.ram_clken      = 1'b1;

  assign rd_pend_d  = any_grant & ~sel_write;
  assign rd_owner_d = grant_id;
  assign rd_oob_d   = oob;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oob_q   <= rd_oob_d;
    end
  end

  // A read granted just before reset must not surface during the reset cycle.
  assign rd_live = rd_pend_q & ~reset;
  assign rdata   = rd_oob_q ? RD_OOB_DATA : bus.ram_readdata;

  assign bus.m0_readdatavalid = rd_live & (rd_owner_q == 1'b0);
  assign bus.m1_readdatavalid = rd_live & (rd_owner_q == 1'b1);
  assign bus.m0_readdata      = bus.m0_readdatavalid ? rdata : 32'h0;
  assign bus.m1_readdata      = bus.m1_readdatavalid ? rdata : 32'h0;

`ifdef RAM_ARB_BOUNDS_CHECK_EN
  logic err_oob_q, err_oob_d;

  assign err_oob_d = err_oob_q | oob;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_oob_q <= 1'b0;
    end else begin
      err_oob_q <= err_oob_d;
    end
  end

  assign err_oob = err_oob_q;
`else
  assign err_oob = 1'b0;
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port on-chip RAM (6000 x 32 bits, byte-enabled, 13-bit word address, 1-cycle read latency, unregistered output) between two Avalon-MM masters: m0 is the CPU data master, m1 is the solver DMA/accelerator.
- Arbitrates one transfer per cycle using weighted round-robin.
- Drives the RAM slave signals and steers returned read data to the owning master with readdatavalid.

Parameters:
- ADDR_W, 13, word-address width.
- DEPTH, 6000, number of implemented words; valid addresses are 0..DEPTH-1.
- MAX_BURST, 4, maximum consecutive grants to one master while the other is waiting (must be >= 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mN_address (N=0,1)  input  ADDR_W  word address.
- mN_read  input  1  read request.
- mN_write  input  1  write request.
- mN_byteenable  input  4  byte lanes for writes.
- mN_writedata  input  32  write data.
- mN_waitrequest  output  1  request not accepted this cycle.
- mN_readdata  output  32  read data.
- mN_readdatavalid  output  1  mN_readdata is valid.
- ram_address  output  ADDR_W  to RAM address.
- ram_byteenable  output  4  to RAM byteenable.
- ram_writedata  output  32  to RAM writedata.
- ram_chipselect  output  1  to RAM chipselect.
- ram_write  output  1  to RAM write.
- ram_clken  output  1  RAM clock enable; constant 1.
- ram_readdata  input  32  from RAM readdata.
- err_oob  output  1  sticky out-of-range flag (optional feature).

Behaviour:
- Request: reqN = mN_read | mN_write. If both read and write are high, the transfer is a write and the read is ignored.
- Grant is combinational, same cycle:
  - Only one master requests: that master is granted.
  - Both request: grant last_grant if burst_cnt < MAX_BURST, otherwise the other master.
- mN_waitrequest = reqN & ~grantN. It is 0 when the master is idle.
- The granted master's address, byteenable and writedata are muxed to ram_*. ram_chipselect = any grant. ram_write = granted write.
- When no master is granted, ram_address, ram_byteenable and ram_writedata hold the m0 values with chipselect=0 and write=0.
- Registered state, updated on each grant:
  - last_grant (1 bit).
  - burst_cnt, width clog2(MAX_BURST+1): set to 1 when the grant goes to a different master than last_grant, otherwise incremented, saturating at MAX_BURST.
  - No grant: both hold.
- Read return: a granted read sets rd_pend=1 and rd_owner=N, registered. The next cycle mN_readdatavalid = rd_pend & (rd_owner==N) and mN_readdata = ram_readdata.
  - The non-owner's readdata is 0.
  - Back-to-back reads from either master or alternating masters are supported: full throughput, one read returned per cycle, latency exactly 1.
- A write followed by a read to the same address in the next cycle returns the new data.
- Reset values:
  - last_grant=1 and burst_cnt=MAX_BURST, so m0 wins the first contention.
  - rd_pend=0 and err_oob=0.
  - All readdatavalid outputs 0, readdata outputs 0.
  - waitrequest outputs follow the combinational rule.
  - ram_clken=1.
- Reset mid-operation: a pending read is discarded and no readdatavalid is issued. During the reset cycle no grant is issued and both waitrequests equal their requests.

Optional Feature:
- Macro RAM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - A granted access with address >= DEPTH is accepted (waitrequest=0) but ram_chipselect and ram_write are forced to 0.
  - A read still returns readdatavalid one cycle later with readdata=32'h0.
  - err_oob sets and stays 1 until reset.
- Undefined: no address check is performed; err_oob is tied to 0.

Decomposition:
- Package ram_arb_pkg holds: ADDR_W and DEPTH defaults, typedef master_id_t (1 bit), and the bounds-check readdata value RD_OOB_DATA = 32'h0.
- One sub-module, rr_grant2: combinational 2-way grant with burst_cnt/last_grant registers, reused for any future two-master shared resources.
- The datapath mux and read-return logic stay in the top level.

Test Plan:
- After reset, m0 and m1 both read every cycle with MAX_BURST=4 -> grants follow m0 x4, m1 x4, m0 x4; each readdatavalid arrives exactly 1 cycle after its grant, to the correct master.
- m0 writes 32'hA5A5_1234 to address 10 with byteenable 4'b0011, then reads address 10 the next cycle -> readdata lower 16 bits are 1234, upper 16 bits hold the prior contents; waitrequest stays 0.
- Only m1 requests for 10 cycles -> waitrequest stays 0 throughout; burst_cnt saturates; the first contention afterwards grants m1 once more only if burst_cnt < 4, otherwise m0.
- Reset is asserted one cycle after m1's read grant -> no m1_readdatavalid appears; after release, the first contention goes to m0.
- With RAM_ARB_BOUNDS_CHECK_EN defined, m0 writes address 6000 then reads 6000 -> ram_chipselect stays 0; readdata=0 with readdatavalid after 1 cycle; err_oob=1 until reset. Without the macro, err_oob stays 0.
